cnn_conv_sched: RTL and testbench
=================================

// Module: cnn_conv_sched
// PURPOSE
//  Layer-level sequencer for the CNNConv systolic datapath. Accepts one conv-layer config and start pulse,
//  programs kernel size (conf_refresh), fetches weight/bias per output-channel group, then sweeps all output positions.
//  Per position it issues one window request; it waits for the pipeline to drain before the next group.
//  Sits between the layer descriptor queue and CNNConv / window generator / weight buffer.
// PARAMETERS
//  KSIZE    3   width of one-hot kernel code; max kernel dimension = KSIZE
//  DIM_W    10  width of feature-map height/width and row/col counters
//  GRP_W    8   width of output-channel group count/index
// PORTS
//  clk            in   1      clock
//  rst            in   1      reset; asynchronous, active-low
//  start          in   1      one-cycle pulse: latch cfg_* and begin layer (ignored unless IDLE)
//  cfg_in_h       in   DIM_W  input feature-map height
//  cfg_in_w       in   DIM_W  input feature-map width
//  cfg_k_h        in   2      kernel height, binary 1..KSIZE
//  cfg_k_w        in   2      kernel width, binary 1..KSIZE
//  cfg_groups     in   GRP_W  number of weight groups (>=1)
//  busy           out  1      high in every state except IDLE
//  done           out  1      one-cycle pulse at layer end
//  err            out  1      sticky config error; cleared by next accepted start
//  conf_refresh   out  1      one-cycle pulse to CNNConv
//  kernel_height  out  KSIZE  one-hot: bit (cfg_k_h-1)
//  kernel_width   out  KSIZE  one-hot: bit (cfg_k_w-1)
//  wgt_req        out  1      weight/bias load request, held until wgt_ack
//  wgt_grp        out  GRP_W  group index being loaded/processed
//  wgt_ack        in   1      weight buffer has driven weight/bias for wgt_grp
//  win_valid      out  1      window request valid (maps to CNNConv window_valid)
//  win_row        out  DIM_W  output row of the requested window
//  win_col        out  DIM_W  output column of the requested window
//  win_stall      in   1      CNNConv window_stall; freezes request stream
//  conv_empty     in   1      CNNConv pipeline empty
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (kernel_height/width=0, counters=0, err=0).
//  Reset assertion mid-layer aborts immediately; no done pulse is generated.
//  Derived at start: OUT_H=cfg_in_h-cfg_k_h+1, OUT_W=cfg_in_w-cfg_k_w+1 (stride 1, no padding).
//  FSM:
//   IDLE   start -> latch cfg. Enter ERR if k=0, k>KSIZE, in_h<k_h, in_w<k_w, or groups=0; else enter CONF.
//   ERR    1 cycle: done=1, err=1 -> IDLE.
//   CONF   1 cycle: conf_refresh=1 with kernel_height/width valid; kernel_* held stable until next start.
//          -> LOAD_W with wgt_grp=0.
//   LOAD_W wgt_req=1 until wgt_ack sampled high (ack in the first cycle allowed).
//          -> RUN with row=col=0.
//   RUN    win_valid=1 each cycle; win_row/win_col = current position.
//          win_stall=1: valid, row and col all hold (request re-presented next cycle).
//          win_stall=0: col++. At col=OUT_W-1, col wraps to 0 and row++.
//          At (OUT_H-1, OUT_W-1) accepted: -> DRAIN.
//          Total accepted requests per group = OUT_H*OUT_W.
//   DRAIN  win_valid=0; minimum 1 cycle; exit on conv_empty=1.
//          If wgt_grp=cfg_groups-1 -> DONE, else wgt_grp++ -> LOAD_W.
//   DONE   1 cycle: done=1 -> IDLE.
//  Accepted start -> conf_refresh latency: exactly 1 cycle. wgt_ack -> first win_valid: 1 cycle.
//  start while busy: ignored, cfg unchanged. wgt_ack outside LOAD_W: ignored.
//  win_stall outside RUN: no effect. Counters are unsigned DIM_W bits; OUT_* never overflow (<=in_*).
//  1x1 output (in=k): RUN lasts exactly one accepted request.
// TESTING
//  T1 in 5x5, k 3x3, groups 1, no stall, immediate ack -> 9 win_valid (0,0)..(2,2) row-major; done once.
//  T2 as T1 with win_stall high 3 cycles at (1,1) -> (1,1) held 4 cycles; still exactly 9 accepted; no skip/dup.
//  T3 in 4x6, k 2x3, groups 3, ack delayed 5 cycles -> wgt_grp 0,1,2; 12 requests each; DRAIN waits for conv_empty.
//  T4 in 2x2, k 3x3 -> ERR: done and err pulse 1 cycle after start; no conf_refresh or wgt_req; err clears on valid start.
//  T5 start pulsed during RUN -> ignored. rst low mid-RUN -> all outputs 0 and IDLE asynchronously; fresh T1 passes.
//  T6 k 1x1, in 3x3 -> kernel_height=kernel_width=3'b001; 9 requests; conf_refresh exactly one cycle.

Source files
------------

// File: rtl/cnn_conv_sched.sv
// Layer sequencer: latches one conv-layer config, programs kernel size, loads weights per group, sweeps output windows.
// Latency: accepted start -> conf_refresh 1 cycle; wgt_ack -> first win_valid 1 cycle; one window request per unstalled cycle.
// Backpressure: win_stall freezes the request stream (valid/row/col hold); wgt_req held until wgt_ack; DRAIN waits for conv_empty.
//
// Ports:
//   clk, rst (async, active-low)
//   start, cfg_in_h/w, cfg_k_h/w, cfg_groups : layer config, sampled on start in IDLE
//   busy, done, err                          : layer status
//   conf_refresh, kernel_height/width        : kernel programming towards CNNConv (one-hot)
//   wgt_req, wgt_grp, wgt_ack                : weight/bias load handshake with the weight buffer
//   win_valid, win_row, win_col, win_stall   : window request stream towards the window generator
//   conv_empty                               : CNNConv pipeline drained
module cnn_conv_sched #(
  parameter int KSIZE = 3,
  parameter int DIM_W = 10,
  parameter int GRP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_in_h,
  input  logic [DIM_W-1:0] cfg_in_w,
  input  logic [1:0]       cfg_k_h,
  input  logic [1:0]       cfg_k_w,
  input  logic [GRP_W-1:0] cfg_groups,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             conf_refresh,
  output logic [KSIZE-1:0] kernel_height,
  output logic [KSIZE-1:0] kernel_width,
  output logic             wgt_req,
  output logic [GRP_W-1:0] wgt_grp,
  input  logic             wgt_ack,
  output logic             win_valid,
  output logic [DIM_W-1:0] win_row,
  output logic [DIM_W-1:0] win_col,
  input  logic             win_stall,
  input  logic             conv_empty
);

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_CONF, S_LOAD, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [DIM_W-1:0] out_h_q, out_h_d;
  logic [DIM_W-1:0] out_w_q, out_w_d;
  logic [GRP_W-1:0] groups_q, groups_d;
  logic [GRP_W-1:0] grp_q, grp_d;
  logic [DIM_W-1:0] row_q, row_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic [KSIZE-1:0] kh_q, kh_d;
  logic [KSIZE-1:0] kw_q, kw_d;
  logic             err_q, err_d;
  logic             cfg_bad;

  // Kernel must be 1..KSIZE in each dimension and fit inside the input map.
  assign cfg_bad = (cfg_k_h == 2'd0) || (cfg_k_w == 2'd0) ||
                   (int'(cfg_k_h) > KSIZE) || (int'(cfg_k_w) > KSIZE) ||
                   (cfg_in_h < DIM_W'(cfg_k_h)) || (cfg_in_w < DIM_W'(cfg_k_w)) ||
                   (cfg_groups == '0);

  always_comb begin
    state_d  = state_q;
    out_h_d  = out_h_q;
    out_w_d  = out_w_q;
    groups_d = groups_q;
    grp_d    = grp_q;
    row_d    = row_q;
    col_d    = col_q;
    kh_d     = kh_q;
    kw_d     = kw_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Stride 1, no padding; only meaningful when the config is valid.
          out_h_d  = cfg_in_h - DIM_W'(cfg_k_h) + DIM_W'(1);
          out_w_d  = cfg_in_w - DIM_W'(cfg_k_w) + DIM_W'(1);
          groups_d = cfg_groups;
          if (cfg_bad) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            err_d   = 1'b0;
            kh_d    = KSIZE'(1) << (cfg_k_h - 2'd1);
            kw_d    = KSIZE'(1) << (cfg_k_w - 2'd1);
            state_d = S_CONF;
          end
        end
      end
      S_ERR:  state_d = S_IDLE;
      S_CONF: begin
        grp_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (wgt_ack) begin
          row_d   = '0;
          col_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!win_stall) begin
          if (col_q == out_w_q - DIM_W'(1)) begin
            col_d = '0;
            if (row_q == out_h_q - DIM_W'(1)) state_d = S_DRAIN;
            else                              row_d   = row_q + DIM_W'(1);
          end else begin
            col_d = col_q + DIM_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (conv_empty) begin
          if (grp_q == groups_q - GRP_W'(1)) begin
            state_d = S_DONE;
          end else begin
            grp_d   = grp_q + GRP_W'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      out_h_q  <= '0;
      out_w_q  <= '0;
      groups_q <= '0;
      grp_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      kh_q     <= '0;
      kw_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_h_q  <= out_h_d;
      out_w_q  <= out_w_d;
      groups_q <= groups_d;
      grp_q    <= grp_d;
      row_q    <= row_d;
      col_q    <= col_d;
      kh_q     <= kh_d;
      kw_q     <= kw_d;
      err_q    <= err_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_ERR) || (state_q == S_DONE);
  assign err           = err_q;
  assign conf_refresh  = (state_q == S_CONF);
  assign kernel_height = kh_q;
  assign kernel_width  = kw_q;
  assign wgt_req       = (state_q == S_LOAD);
  assign wgt_grp       = grp_q;
  assign win_valid     = (state_q == S_RUN);
  assign win_row       = row_q;
  assign win_col       = col_q;

endmodule

// File: tb/tb_cnn_conv_sched.sv
// Scoreboard bench for cnn_conv_sched: stimulus pushes expected windows/kernels/done events,
// a negedge monitor pops and compares, and also acts as weight-buffer / CNNConv responder.
// Responder knobs (ack delay, drain delay, stall position/count) are set by the stimulus.
module tb_cnn_conv_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [9:0] cfg_in_h = '0;
  logic [9:0] cfg_in_w = '0;
  logic [1:0] cfg_k_h = '0;
  logic [1:0] cfg_k_w = '0;
  logic [7:0] cfg_groups = '0;
  logic       busy, done, err, conf_refresh, wgt_req, win_valid;
  logic [2:0] kernel_height, kernel_width;
  logic [7:0] wgt_grp;
  logic [9:0] win_row, win_col;
  logic       wgt_ack = 1'b0;
  logic       win_stall = 1'b0;
  logic       conv_empty = 1'b1;

  cnn_conv_sched #(.KSIZE(3), .DIM_W(10), .GRP_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_in_h(cfg_in_h), .cfg_in_w(cfg_in_w), .cfg_k_h(cfg_k_h), .cfg_k_w(cfg_k_w),
    .cfg_groups(cfg_groups),
    .busy(busy), .done(done), .err(err),
    .conf_refresh(conf_refresh), .kernel_height(kernel_height), .kernel_width(kernel_width),
    .wgt_req(wgt_req), .wgt_grp(wgt_grp), .wgt_ack(wgt_ack),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col), .win_stall(win_stall),
    .conv_empty(conv_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       last;
    logic [7:0] g;
    logic [9:0] r;
    logic [9:0] c;
  } win_t;

  win_t       exp_win[$];
  logic [5:0] exp_conf[$];
  logic       exp_done[$];

  int total = 0;
  int bad   = 0;

  // responder knobs (written by stimulus only)
  int ack_delay   = 0;
  int drain_delay = 0;
  int stall_n     = 0;
  int stall_r     = 1;
  int stall_c     = 1;
  // responder state (written by monitor only)
  int ack_cnt   = 0;
  int drain_cnt = 0;
  int stall_used = 0;
  int hold_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic note_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor + responder
  always @(negedge clk) begin
    win_t e;
    if (!rst) begin
      wgt_ack    = 1'b0;
      win_stall  = 1'b0;
      conv_empty = 1'b1;
      ack_cnt    = 0;
      drain_cnt  = 0;
    end else begin
      if (start) begin
        stall_used = 0;
        hold_cnt   = 0;
      end
      if (drain_cnt > 0) begin
        chk("drain_hold", {29'd0, wgt_req, done, win_valid}, 32'd0);
        drain_cnt--;
        if (drain_cnt == 0) conv_empty = 1'b1;
      end
      if (wgt_req) begin
        wgt_ack = (ack_cnt >= ack_delay);
        ack_cnt++;
      end else begin
        wgt_ack = 1'b0;
        ack_cnt = 0;
      end
      if (conf_refresh) begin
        if (exp_conf.size() == 0) note_fail("conf_unexpected");
        else chk("conf_kernel", {26'd0, kernel_height, kernel_width}, {26'd0, exp_conf.pop_front()});
      end
      if (done) begin
        if (exp_done.size() == 0) note_fail("done_unexpected");
        else chk("done_err", {31'd0, err}, {31'd0, exp_done.pop_front()});
      end
      if (win_valid) begin
        if (stall_used < stall_n && int'(win_row) == stall_r && int'(win_col) == stall_c) begin
          win_stall = 1'b1;
          stall_used++;
        end else begin
          win_stall = 1'b0;
        end
        if (exp_win.size() == 0) begin
          note_fail("win_unexpected");
        end else begin
          e = exp_win[0];
          chk("win_pos", {4'd0, wgt_grp, win_row, win_col}, {4'd0, e.g, e.r, e.c});
          if (int'(win_row) == stall_r && int'(win_col) == stall_c) hold_cnt++;
          if (!win_stall) begin
            void'(exp_win.pop_front());
            if (e.last) begin
              drain_cnt = drain_delay;
              if (drain_delay > 0) conv_empty = 1'b0;
            end
          end
        end
      end else begin
        win_stall = 1'b0;
      end
    end
  end

  task automatic pulse_start(input int ih, input int iw, input int kh, input int kw, input int g);
    @(posedge clk); #1;
    cfg_in_h   = 10'(ih);
    cfg_in_w   = 10'(iw);
    cfg_k_h    = 2'(kh);
    cfg_k_w    = 2'(kw);
    cfg_groups = 8'(g);
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic launch(input int ih, input int iw, input int kh, input int kw, input int g);
    win_t w;
    int oh, ow;
    bit ok;
    ok = (kh >= 1) && (kh <= 3) && (kw >= 1) && (kw <= 3) && (ih >= kh) && (iw >= kw) && (g >= 1);
    if (!ok) begin
      exp_done.push_back(1'b1);
    end else begin
      oh = ih - kh + 1;
      ow = iw - kw + 1;
      exp_conf.push_back({3'(1 << (kh - 1)), 3'(1 << (kw - 1))});
      for (int gi = 0; gi < g; gi++)
        for (int r = 0; r < oh; r++)
          for (int c = 0; c < ow; c++) begin
            w.last = (r == oh - 1) && (c == ow - 1);
            w.g = 8'(gi);
            w.r = 10'(r);
            w.c = 10'(c);
            exp_win.push_back(w);
          end
      exp_done.push_back(1'b0);
    end
    pulse_start(ih, iw, kh, kw, g);
  endtask

  task automatic finish_layer(input string tag);
    int n = 0;
    while ((exp_done.size() != 0 || busy) && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 3000) note_fail({tag, "_timeout"});
    chk({tag, "_win_left"}, exp_win.size(), 0);
    chk({tag, "_conf_left"}, exp_conf.size(), 0);
  endtask

  task automatic wait_win_left(input int lim);
    int n = 0;
    while (exp_win.size() > lim && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 500) note_fail("wait_win_timeout");
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_status", {26'd0, busy, done, err, conf_refresh, wgt_req, win_valid}, 32'd0);
    chk("rst_kernel", {26'd0, kernel_height, kernel_width}, 32'd0);
    chk("rst_ctrs", {4'd0, wgt_grp, win_row, win_col}, 32'd0);
    #14 rst = 1'b1;

    // T1: 5x5, k3x3, 1 group, immediate ack
    launch(5, 5, 3, 3, 1);
    finish_layer("t1");

    // T2: stall three cycles at (1,1)
    stall_r = 1; stall_c = 1; stall_n = 3;
    launch(5, 5, 3, 3, 1);
    finish_layer("t2");
    chk("t2_hold_cycles", hold_cnt, 4);
    stall_n = 0;

    // T3: 4x6, k2x3, 3 groups, slow ack, slow drain
    ack_delay = 5; drain_delay = 3;
    launch(4, 6, 2, 3, 3);
    finish_layer("t3");
    ack_delay = 0; drain_delay = 0;

    // T4: kernel larger than input -> ERR
    launch(2, 2, 3, 3, 1);
    @(negedge clk);
    chk("t4_err_lat", {28'd0, done, err, conf_refresh, wgt_req}, 32'b1100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_err_sticky", {27'd0, done, err, conf_refresh, wgt_req, busy}, 32'b01000);
    end
    finish_layer("t4");
    // other error sources: zero kernel, zero groups
    launch(5, 5, 0, 3, 1);
    finish_layer("t4_k0");
    launch(5, 5, 3, 3, 0);
    finish_layer("t4_g0");

    // T6: 1x1 kernel on 3x3; also err cleared by this valid start
    launch(3, 3, 1, 1, 1);
    @(negedge clk);
    chk("t6_err_clear", {31'd0, err}, 32'd0);
    chk("t6_conf_lat", {31'd0, conf_refresh}, 32'd1);
    @(negedge clk);
    chk("t6_conf_1cyc", {31'd0, conf_refresh}, 32'd0);
    finish_layer("t6");

    // T5a: start during RUN is ignored
    launch(5, 5, 3, 3, 1);
    wait_win_left(5);
    pulse_start(3, 3, 1, 1, 2);
    finish_layer("t5_ignore");

    // T5b: asynchronous reset mid-RUN
    launch(5, 5, 3, 3, 2);
    wait_win_left(12);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("t5_rst_status", {26'd0, busy, done, err, conf_refresh, wgt_req, win_valid}, 32'd0);
    chk("t5_rst_kernel", {26'd0, kernel_height, kernel_width}, 32'd0);
    chk("t5_rst_ctrs", {4'd0, wgt_grp, win_row, win_col}, 32'd0);
    exp_win.delete();
    exp_conf.delete();
    exp_done.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    launch(5, 5, 3, 3, 1);
    finish_layer("t5_fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
